tdm_demux4: RTL and testbench
=============================

// Module: tdm_demux4
// PURPOSE
//  Receive-side partner of the 4:1 select mux. Takes one time-division-multiplexed
//  stream (one lane per beat, slot 0 flagged by frame_sync) and distributes the beats
//  round-robin onto four registered output lanes y0..y3.
//  Provides per-lane valid pulses, an end-of-frame pulse and sync-error detection.
//  Sits between a serial/TDM link and four independent lane consumers.
// PARAMETERS
//  WIDTH      1   bits per beat / per output lane
// PORTS
//  clk         in   1       single clock, all state on rising edge
//  rst         in   1       asynchronous, active-high reset
//  din         in   WIDTH   TDM data beat
//  din_valid   in   1       din carries a beat this cycle
//  frame_sync  in   1       qualified by din_valid: this beat is slot 0
//  resync      in   1       synchronous: drop lock, return to HUNT
//  y0..y3      out  WIDTH   lane outputs, hold last captured value
//  y_valid     out  4       one-cycle pulse, bit n = yn updated this cycle
//  frame_done  out  1       one-cycle pulse, slot 3 captured (frame complete)
//  sync_err    out  1       one-cycle pulse, frame_sync seen at slot != 0 while locked
//  locked      out  1       1 in SYNC state
// BEHAVIOUR
//  - Reset (async, any time incl. mid-frame): y0..y3=0, y_valid=0, frame_done=0,
//    sync_err=0, locked=0, slot=0, state=HUNT. Partial frame discarded.
//  - Latency: all outputs registered; beat at edge N appears on yn/y_valid at N+1.
//  - Beat = din_valid==1. Cycles with din_valid==0: slot holds, all pulses 0,
//    y0..y3 hold. frame_sync without din_valid ignored.
//  - FSM states: HUNT, SYNC.
//    HUNT: beats without frame_sync dropped (no outputs). Beat with frame_sync ->
//      y0<=din, y_valid=0001, slot<=1, state<=SYNC.
//    SYNC: beat, no frame_sync -> y[slot]<=din, y_valid=onehot(slot), slot<=slot+1
//      (3 wraps to 0); frame_done=1 when slot==3.
//      beat with frame_sync and slot==0 -> normal slot-0 capture, no error.
//      beat with frame_sync and slot!=0 -> sync_err=1, partial frame abandoned,
//      beat taken as slot 0 (y0<=din, y_valid=0001, slot<=1); no frame_done.
//  - resync=1 has priority over any beat that cycle: state<=HUNT, slot<=0,
//    beat dropped, no pulses; y0..y3 keep values.
//  - locked reflects registered state (0 in HUNT, 1 in SYNC).
//  - Lanes not updated keep their previous value; y_valid never multi-hot.
// STRUCTURE
//  - Shared header tdm_defs.vh: state encodings HUNT=1'b0, SYNC=1'b1; TDM_LANES=4;
//    slot width 2. Same header to be used by the matching TDM mux transmitter.
//  - Single module; no sub-module. Slot counter, FSM and 4-lane register bank inline.
// TESTING
//  1 Reset: rst=1 mid-stream -> all outputs 0, locked=0 immediately (no clk edge needed).
//  2 Lock+frame (WIDTH=1): beats 1(sync),0,1,1 -> after 4 beats y0..y3=1,0,1,1,
//    y_valid 0001,0010,0100,1000 on consecutive cycles, frame_done on 4th, locked=1.
//  3 HUNT drop: beats 1,1 without sync then 0(sync) -> no y_valid until sync beat,
//    then y0=0, y_valid=0001.
//  4 Gaps: frame with din_valid=0 between every beat -> same lane values as test 2,
//    pulses only on beat cycles, slot unchanged across gaps.
//  5 Misalign: locked, sync on 3rd beat -> sync_err=1 that cycle+1, y_valid=0001,
//    no frame_done; next 3 beats fill y1..y3 and raise frame_done.
//  6 resync + async reset mid-frame at slot 2 -> HUNT, locked=0, pending beat dropped,
//    y0..y3 retained (resync) / cleared (rst); re-lock on next sync beat.
//  Plus 200-cycle random stream vs. reference model, WIDTH=1 and WIDTH=8.

Source files
------------

// File: rtl/tdm_demux4_pkg.sv
// Shared TDM definitions: state encodings, lane count and slot helpers.
// The matching TDM mux transmitter imports the same package.
package tdm_demux4_pkg;

    localparam int TDM_LANES = 4;
    localparam int SLOT_W    = 2;

    typedef enum logic {
        HUNT = 1'b0,
        SYNC = 1'b1
    } tdm_state_e;

    typedef logic [SLOT_W-1:0]    slot_t;
    typedef logic [TDM_LANES-1:0] lane_mask_t;

    localparam slot_t SLOT_FIRST = slot_t'(0);
    localparam slot_t SLOT_LAST  = slot_t'(TDM_LANES - 1);

    function automatic lane_mask_t slot_onehot(input slot_t s);
        lane_mask_t m;
        m = '0;
        m[s] = 1'b1;
        return m;
    endfunction

    function automatic slot_t slot_advance(input slot_t s);
        return (s == SLOT_LAST) ? SLOT_FIRST : slot_t'(s + slot_t'(1));
    endfunction

endpackage

// File: rtl/tdm_demux4.sv
// Receive-side 1:4 TDM demultiplexer: locks on frame_sync, distributes beats
// round-robin onto four registered lanes with valid, frame and sync-error pulses.
//
// state | meaning
// HUNT  | no frame lock; beats dropped until one arrives with frame_sync
// SYNC  | locked; each beat lands on lane[slot], slot advances modulo 4
module tdm_demux4
    import tdm_demux4_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             frame_sync,
    input  logic             resync,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic [WIDTH-1:0] y2,
    output logic [WIDTH-1:0] y3,
    output logic [3:0]       y_valid,
    output logic             frame_done,
    output logic             sync_err,
    output logic             locked
);

    tdm_state_e       state, state_nxt;
    slot_t            slot, slot_nxt;
    lane_mask_t       cap_en;
    logic             frame_done_nxt;
    logic             sync_err_nxt;
    logic [WIDTH-1:0] lane_q [TDM_LANES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= HUNT;
            slot       <= SLOT_FIRST;
            y_valid    <= '0;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            state      <= state_nxt;
            slot       <= slot_nxt;
            y_valid    <= cap_en;
            frame_done <= frame_done_nxt;
            sync_err   <= sync_err_nxt;
        end
    end

    // resync outranks any beat in the same cycle; lanes are left untouched
    always_comb begin
        state_nxt      = state;
        slot_nxt       = slot;
        cap_en         = '0;
        frame_done_nxt = 1'b0;
        sync_err_nxt   = 1'b0;
        if (resync) begin
            state_nxt = HUNT;
            slot_nxt  = SLOT_FIRST;
        end else if (din_valid) begin
            case (state)
                HUNT: begin
                    if (frame_sync) begin
                        cap_en    = slot_onehot(SLOT_FIRST);
                        slot_nxt  = slot_advance(SLOT_FIRST);
                        state_nxt = SYNC;
                    end
                end
                SYNC: begin
                    if (frame_sync && (slot != SLOT_FIRST)) begin
                        // misplaced sync: abandon partial frame, restart at slot 0
                        sync_err_nxt = 1'b1;
                        cap_en       = slot_onehot(SLOT_FIRST);
                        slot_nxt     = slot_advance(SLOT_FIRST);
                    end else begin
                        cap_en         = slot_onehot(slot);
                        slot_nxt       = slot_advance(slot);
                        frame_done_nxt = (slot == SLOT_LAST);
                    end
                end
                default: begin
                    state_nxt = HUNT;
                    slot_nxt  = SLOT_FIRST;
                end
            endcase
        end
    end

    for (genvar n = 0; n < TDM_LANES; n++) begin : g_lane
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                lane_q[n] <= '0;
            end else if (cap_en[n]) begin
                lane_q[n] <= din;
            end
        end
    end

    assign y0     = lane_q[0];
    assign y1     = lane_q[1];
    assign y2     = lane_q[2];
    assign y3     = lane_q[3];
    assign locked = (state == SYNC);

endmodule

// File: tb/tb_tdm_demux4.sv
// Bench for tdm_demux4: WIDTH=8 and WIDTH=1 instances share one stimulus stream
// and are checked every cycle against a queued reference model.
module tb_tdm_demux4;

    logic       clk = 1'b0;
    logic       rst;
    logic       din_valid, frame_sync, resync;
    logic [7:0] din8;
    logic       din1;

    logic [7:0] y8_0, y8_1, y8_2, y8_3;
    logic [3:0] yv8;
    logic       fd8, se8, lk8;
    logic       y1_0, y1_1, y1_2, y1_3;
    logic [3:0] yv1;
    logic       fd1, se1, lk1;

    assign din1 = din8[0];

    always #5 clk = ~clk;

    tdm_demux4 #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .din(din8), .din_valid(din_valid),
        .frame_sync(frame_sync), .resync(resync),
        .y0(y8_0), .y1(y8_1), .y2(y8_2), .y3(y8_3),
        .y_valid(yv8), .frame_done(fd8), .sync_err(se8), .locked(lk8)
    );

    tdm_demux4 #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .din(din1), .din_valid(din_valid),
        .frame_sync(frame_sync), .resync(resync),
        .y0(y1_0), .y1(y1_1), .y2(y1_2), .y3(y1_3),
        .y_valid(yv1), .frame_done(fd1), .sync_err(se1), .locked(lk1)
    );

    typedef struct packed {
        logic [31:0] y;
        logic [3:0]  yv;
        logic        fd;
        logic        se;
        logic        lk;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // reference model state
    logic [7:0] m_y [4];
    bit         m_locked;
    int         m_slot;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_y[i] = '0;
        m_locked = 0;
        m_slot   = 0;
    endtask

    task automatic model_step(input logic v, input logic fs, input logic [7:0] d,
                              input logic rs, output exp_t e);
        e = '0;
        if (rs) begin
            m_locked = 0;
            m_slot   = 0;
        end else if (v) begin
            if (!m_locked) begin
                if (fs) begin
                    m_y[0]   = d;
                    e.yv     = 4'b0001;
                    m_slot   = 1;
                    m_locked = 1;
                end
            end else begin
                if (fs) begin
                    e.se   = (m_slot != 0);
                    m_slot = 0;
                end
                m_y[m_slot] = d;
                e.yv        = 4'(1 << m_slot);
                e.fd        = (m_slot == 3);
                m_slot      = (m_slot + 1) % 4;
            end
        end
        e.y  = {m_y[3], m_y[2], m_y[1], m_y[0]};
        e.lk = m_locked;
    endtask

    task automatic compare_all();
        exp_t e;
        if (q.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
            return;
        end
        e = q.pop_front();
        check("y_w8",  {y8_3, y8_2, y8_1, y8_0}, e.y);
        check("y_w1",  {28'd0, y1_3, y1_2, y1_1, y1_0},
              {28'd0, e.y[24], e.y[16], e.y[8], e.y[0]});
        check("yv_w8", {28'd0, yv8}, {28'd0, e.yv});
        check("yv_w1", {28'd0, yv1}, {28'd0, e.yv});
        check("fd_w8", {31'd0, fd8}, {31'd0, e.fd});
        check("fd_w1", {31'd0, fd1}, {31'd0, e.fd});
        check("se_w8", {31'd0, se8}, {31'd0, e.se});
        check("se_w1", {31'd0, se1}, {31'd0, e.se});
        check("lk_w8", {31'd0, lk8}, {31'd0, e.lk});
        check("lk_w1", {31'd0, lk1}, {31'd0, e.lk});
    endtask

    task automatic step(input logic v, input logic fs, input logic [7:0] d, input logic rs);
        exp_t e;
        @(negedge clk);
        din_valid  = v;
        frame_sync = fs;
        din8       = d;
        resync     = rs;
        model_step(v, fs, d, rs, e);
        q.push_back(e);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_y8"}, {y8_3, y8_2, y8_1, y8_0}, 32'd0);
        check({tag, "_y1"}, {28'd0, y1_3, y1_2, y1_1, y1_0}, 32'd0);
        check({tag, "_pulses"}, {22'd0, yv8, yv1, fd8, fd1, se8, se1}, 32'd0);
        check({tag, "_locked"}, {30'd0, lk8, lk1}, 32'd0);
    endtask

    // reset asserted between edges; outputs must clear without a clock edge
    task automatic async_reset(input string tag);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_all_zero(tag);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        din_valid = 0; frame_sync = 0; resync = 0; din8 = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_all_zero("reset_init");
        @(negedge clk);
        rst = 1'b0;

        // lock + one full frame: 1(sync),0,1,1
        step(1, 1, 8'h01, 0);
        step(1, 0, 8'h00, 0);
        step(1, 0, 8'h81, 0);
        step(1, 0, 8'h7f, 0);
        check("t2_lanes", {28'd0, y1_3, y1_2, y1_1, y1_0}, 32'b1101);
        check("t2_frame_done", {31'd0, fd1}, 32'd1);

        // HUNT drops unsynced beats
        async_reset("reset_t3");
        step(1, 0, 8'hff, 0);
        step(1, 0, 8'hff, 0);
        step(0, 1, 8'hff, 0);
        step(1, 1, 8'h00, 0);
        check("t3_yv", {28'd0, yv1}, 32'b0001);

        // gaps between beats, stray frame_sync on gap cycles ignored
        step(0, 0, 8'h00, 0);
        step(1, 0, 8'h33, 0);
        step(0, 1, 8'hee, 0);
        step(1, 0, 8'h44, 0);
        step(0, 0, 8'hdd, 0);
        step(1, 0, 8'h55, 0);
        step(0, 0, 8'h00, 0);
        step(1, 1, 8'h11, 0);

        // misaligned sync on 3rd beat
        step(1, 0, 8'h22, 0);
        step(1, 1, 8'ha5, 0);
        check("t5_sync_err", {31'd0, se8}, 32'd1);
        check("t5_no_fd", {31'd0, fd8}, 32'd0);
        step(1, 0, 8'hb1, 0);
        step(1, 0, 8'hb2, 0);
        step(1, 0, 8'hb3, 0);
        check("t5_fd", {31'd0, fd8}, 32'd1);

        // resync mid-frame at slot 2 with a beat pending
        step(1, 1, 8'hc0, 0);
        step(1, 0, 8'hc1, 0);
        step(1, 1, 8'hc2, 1);
        check("t6_resync_unlock", {31'd0, lk8}, 32'd0);
        step(1, 0, 8'hc3, 0);
        step(1, 1, 8'hd0, 0);
        step(1, 0, 8'hd1, 0);
        async_reset("reset_t6");
        step(1, 0, 8'he0, 0);
        step(1, 1, 8'he1, 0);

        // random stream
        for (int i = 0; i < 200; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0,
                 8'($urandom), $urandom_range(0, 39) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
